// File: rtl/tinker_pkg.sv
// Shared types for the data-port scheduler: scheduler states, the held
// request record and the default unified-memory size.
package tinker_pkg;

    localparam int unsigned MEM_BYTES_DEFAULT = 524288;

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } sched_state_t;

    typedef struct packed {
        logic        write;
        logic [63:0] addr;
        logic [63:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/dmem_port_scheduler.sv
// Serializes the two issue slots' loads/stores onto the single data port,
// holding slot 1 for one cycle when both slots request in the same bundle.
module dmem_port_scheduler
    import tinker_pkg::*;
#(
    parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic             req0_write,
    input  logic [63:0]      req0_addr,
    input  logic [63:0]      req0_wdata,
    input  logic             req1_valid,
    input  logic             req1_write,
    input  logic [63:0]      req1_addr,
    input  logic [63:0]      req1_wdata,
    input  logic             flush,
    output logic [63:0]      mem_addr,
    output logic             mem_we,
    output logic [63:0]      mem_wdata,
    input  logic [63:0]      mem_rdata,
    output logic             stall,
    output logic             resp0_valid,
    output logic [63:0]      resp0_rdata,
    output logic             resp1_valid,
    output logic [63:0]      resp1_rdata,
    output logic             addr_err,
    output logic [CNT_W-1:0] cnt_grant0,
    output logic [CNT_W-1:0] cnt_grant1,
    output logic [CNT_W-1:0] cnt_conflict
);

    localparam logic [63:0] ADDR_MAX = 64'(MEM_BYTES) - 64'd8;

    sched_state_t state_reg, state_next;
    mem_req_t     hold_reg;
    mem_req_t     gnt;
    logic         gnt_valid;
    logic         gnt_slot1;
    logic         capture;
    logic         conflict;
    logic         in_range;
    logic         load0;
    logic         load1;

    always_comb begin
        state_next = state_reg;
        gnt        = '0;
        gnt_valid  = 1'b0;
        gnt_slot1  = 1'b0;
        capture    = 1'b0;
        conflict   = 1'b0;
        stall      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req0_valid) begin
                    gnt       = '{req0_write, req0_addr, req0_wdata};
                    gnt_valid = 1'b1;
                    if (req1_valid) begin
                        conflict = 1'b1;
                        // A flush in the bundle kills slot 1 before it is ever held.
                        if (!flush) begin
                            capture    = 1'b1;
                            stall      = 1'b1;
                            state_next = HELD;
                        end
                    end
                end else if (req1_valid) begin
                    gnt       = '{req1_write, req1_addr, req1_wdata};
                    gnt_valid = 1'b1;
                    gnt_slot1 = 1'b1;
                end
            end
            HELD: begin
                stall      = 1'b1;
                state_next = IDLE;
                if (!flush) begin
                    gnt       = hold_reg;
                    gnt_valid = 1'b1;
                    gnt_slot1 = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        in_range  = (gnt.addr <= ADDR_MAX);
        load0     = gnt_valid && !gnt_slot1 && !gnt.write;
        load1     = gnt_valid && gnt_slot1 && !gnt.write;
        mem_addr  = gnt.addr;
        mem_wdata = gnt.wdata;
        mem_we    = gnt_valid && gnt.write && in_range;

        if (reset) begin
            mem_addr  = '0;
            mem_wdata = '0;
            mem_we    = 1'b0;
            stall     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            hold_reg    <= '0;
            resp0_valid <= 1'b0;
            resp0_rdata <= '0;
            resp1_valid <= 1'b0;
            resp1_rdata <= '0;
            addr_err    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (capture) begin
                hold_reg <= '{req1_write, req1_addr, req1_wdata};
            end
            // Out-of-range loads still respond, but with zero data.
            resp0_valid <= load0;
            resp0_rdata <= (load0 && in_range) ? mem_rdata : '0;
            resp1_valid <= load1;
            resp1_rdata <= (load1 && in_range) ? mem_rdata : '0;
            addr_err    <= gnt_valid && !in_range;
        end
    end

    logic [2:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_val [3];

    assign cnt_inc = {conflict, gnt_valid && gnt_slot1, gnt_valid && !gnt_slot1};

    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
        sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .inc   (cnt_inc[gi]),
            .count (cnt_val[gi])
        );
    end

    assign cnt_grant0   = cnt_val[0];
    assign cnt_grant1   = cnt_val[1];
    assign cnt_conflict = cnt_val[2];

endmodule

// File: tb/tb_dmem_port_scheduler.sv
// Directed vector bench for dmem_port_scheduler with a small word memory
// model on the data port; counters are narrowed so saturation is reachable.
module tb_dmem_port_scheduler;

    localparam int unsigned MEM_BYTES = 524288;
    localparam int          CNT_W     = 4;

    logic        clk;
    logic        reset;
    logic        req0_valid, req0_write, req1_valid, req1_write, flush;
    logic [63:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, stall;
    logic        resp0_valid, resp1_valid, addr_err;
    logic [63:0] resp0_rdata, resp1_rdata;
    logic [CNT_W-1:0] cnt_grant0, cnt_grant1, cnt_conflict;

    logic        pre_we;
    logic [9:0]  pre_idx;
    logic [63:0] pre_data;
    logic [63:0] mem [0:1023];

    int n_cmp;
    int n_bad;

    dmem_port_scheduler #(.MEM_BYTES(MEM_BYTES), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .req0_valid   (req0_valid),
        .req0_write   (req0_write),
        .req0_addr    (req0_addr),
        .req0_wdata   (req0_wdata),
        .req1_valid   (req1_valid),
        .req1_write   (req1_write),
        .req1_addr    (req1_addr),
        .req1_wdata   (req1_wdata),
        .flush        (flush),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .stall        (stall),
        .resp0_valid  (resp0_valid),
        .resp0_rdata  (resp0_rdata),
        .resp1_valid  (resp1_valid),
        .resp1_rdata  (resp1_rdata),
        .addr_err     (addr_err),
        .cnt_grant0   (cnt_grant0),
        .cnt_grant1   (cnt_grant1),
        .cnt_conflict (cnt_conflict)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Word-indexed memory; out-of-range addresses alias so a leaked store is visible.
    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_data;
        else if (mem_we) mem[mem_addr[12:3]] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr[12:3]];

    typedef struct {
        bit          r0v, r0w;
        logic [63:0] r0a, r0d;
        bit          r1v, r1w;
        logic [63:0] r1a, r1d;
        bit          fl;
        bit          e_stall, e_we;
        logic [63:0] e_addr, e_wdata;
        bit          e_r0v;
        logic [63:0] e_r0d;
        bit          e_r1v;
        logic [63:0] e_r1d;
        bit          e_err;
        int          e_g0, e_g1, e_c;
    } vec_t;

    vec_t tbl [22];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        req0_valid = 0; req0_write = 0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 0; req1_write = 0; req1_addr = '0; req1_wdata = '0;
        flush = 0;
    endtask

    task automatic apply(input int idx, input vec_t v);
        @(negedge clk);
        req0_valid = v.r0v; req0_write = v.r0w; req0_addr = v.r0a; req0_wdata = v.r0d;
        req1_valid = v.r1v; req1_write = v.r1w; req1_addr = v.r1a; req1_wdata = v.r1d;
        flush = v.fl;
        #1;
        $display("row %0d: stall=%0b we=%0b addr=0x%0h r0=%0b/0x%0h r1=%0b/0x%0h err=%0b cnt=%0d/%0d/%0d",
                 idx, stall, mem_we, mem_addr, resp0_valid, resp0_rdata, resp1_valid, resp1_rdata,
                 addr_err, cnt_grant0, cnt_grant1, cnt_conflict);
        chk($sformatf("row%0d stall", idx), {63'd0, stall}, {63'd0, v.e_stall});
        chk($sformatf("row%0d mem_we", idx), {63'd0, mem_we}, {63'd0, v.e_we});
        chk($sformatf("row%0d mem_addr", idx), mem_addr, v.e_addr);
        chk($sformatf("row%0d mem_wdata", idx), mem_wdata, v.e_wdata);
        chk($sformatf("row%0d resp0_valid", idx), {63'd0, resp0_valid}, {63'd0, v.e_r0v});
        chk($sformatf("row%0d resp0_rdata", idx), resp0_rdata, v.e_r0d);
        chk($sformatf("row%0d resp1_valid", idx), {63'd0, resp1_valid}, {63'd0, v.e_r1v});
        chk($sformatf("row%0d resp1_rdata", idx), resp1_rdata, v.e_r1d);
        chk($sformatf("row%0d addr_err", idx), {63'd0, addr_err}, {63'd0, v.e_err});
        chk($sformatf("row%0d cnt_grant0", idx), 64'(cnt_grant0), 64'(v.e_g0));
        chk($sformatf("row%0d cnt_grant1", idx), 64'(cnt_grant1), 64'(v.e_g1));
        chk($sformatf("row%0d cnt_conflict", idx), 64'(cnt_conflict), 64'(v.e_c));
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        // r0v r0w r0a r0d | r1v r1w r1a r1d | fl | stall we addr wdata | r0v r0d r1v r1d err | g0 g1 c
        tbl[0]  = '{1,0,64'h100,0,         0,0,0,0,            0, 0,0,64'h100,0,          0,0,0,0,0,                   0,0,0};
        tbl[1]  = '{0,0,0,0,               0,0,0,0,            0, 0,0,0,0,                1,64'hDEADBEEF,0,0,0,        1,0,0};
        tbl[2]  = '{1,1,64'h200,5,         1,0,64'h200,0,      0, 1,1,64'h200,5,          0,0,0,0,0,                   1,0,0};
        tbl[3]  = '{1,0,64'h100,0,         0,0,0,0,            0, 1,0,64'h200,0,          0,0,0,0,0,                   2,0,1};
        tbl[4]  = '{0,0,0,0,               0,0,0,0,            0, 0,0,0,0,                0,0,1,5,0,                   2,1,1};
        tbl[5]  = '{1,0,64'h100,0,         1,1,64'h300,7,      0, 1,0,64'h100,0,          0,0,0,0,0,                   2,1,1};
        tbl[6]  = '{0,0,0,0,               0,0,0,0,            1, 1,0,0,0,                1,64'hDEADBEEF,0,0,0,        3,1,2};
        tbl[7]  = '{1,0,64'h300,0,         0,0,0,0,            0, 0,0,64'h300,0,          0,0,0,0,0,                   3,1,2};
        tbl[8]  = '{0,0,0,0,               0,0,0,0,            0, 0,0,0,0,                1,64'hAA,0,0,0,              4,1,2};
        tbl[9]  = '{1,0,64'h100,0,         1,0,64'h200,0,      1, 0,0,64'h100,0,          0,0,0,0,0,                   4,1,2};
        tbl[10] = '{0,0,0,0,               1,0,64'h100,0,      0, 0,0,64'h100,0,          1,64'hDEADBEEF,0,0,0,        5,1,3};
        tbl[11] = '{0,0,0,0,               0,0,0,0,            0, 0,0,0,0,                0,0,1,64'hDEADBEEF,0,        5,2,3};
        tbl[12] = '{1,1,64'h7FFF9,64'h99,  0,0,0,0,            0, 0,0,64'h7FFF9,64'h99,   0,0,0,0,0,                   5,2,3};
        tbl[13] = '{1,0,64'h7FFF8,0,       0,0,0,0,            0, 0,0,64'h7FFF8,0,        0,0,0,0,1,                   6,2,3};
        tbl[14] = '{0,0,0,0,               1,0,64'h80000,0,    0, 0,0,64'h80000,0,        1,64'h1234,0,0,0,            7,2,3};
        tbl[15] = '{1,0,64'h1_0000_0100,0, 0,0,0,0,            0, 0,0,64'h1_0000_0100,0,  0,0,1,0,1,                   7,3,3};
        tbl[16] = '{0,0,0,0,               0,0,0,0,            0, 0,0,0,0,                1,0,0,0,1,                   8,3,3};
        tbl[17] = '{1,0,64'h100,0,         1,0,64'h7FFF8,0,    0, 1,0,64'h100,0,          0,0,0,0,0,                   8,3,3};
        tbl[18] = '{0,0,0,0,               0,0,0,0,            0, 1,0,64'h7FFF8,0,        1,64'hDEADBEEF,0,0,0,        9,3,4};
        tbl[19] = '{1,0,64'h7FFF8,0,       1,0,64'h100,0,      0, 1,0,64'h7FFF8,0,        0,0,1,64'h1234,0,            9,4,4};
        tbl[20] = '{0,0,0,0,               0,0,0,0,            0, 1,0,64'h100,0,          1,64'h1234,0,0,0,            10,4,5};
        tbl[21] = '{0,0,0,0,               0,0,0,0,            0, 0,0,0,0,                0,0,1,64'hDEADBEEF,0,        10,5,5};

        // Reset with live requests: port and stall must stay quiet.
        reset = 1'b1;
        pre_we = 1'b0; pre_idx = '0; pre_data = '0;
        drive_idle();
        req0_valid = 1; req0_addr = 64'h100; req1_valid = 1; req1_addr = 64'h200; req1_write = 1;
        #1;
        $display("reset: stall=%0b we=%0b addr=0x%0h", stall, mem_we, mem_addr);
        chk("reset stall", {63'd0, stall}, 64'd0);
        chk("reset mem_we", {63'd0, mem_we}, 64'd0);
        chk("reset mem_addr", mem_addr, 64'd0);
        chk("reset mem_wdata", mem_wdata, 64'd0);
        chk("reset resp0_valid", {63'd0, resp0_valid}, 64'd0);
        chk("reset resp1_valid", {63'd0, resp1_valid}, 64'd0);
        chk("reset addr_err", {63'd0, addr_err}, 64'd0);
        chk("reset cnt_conflict", 64'(cnt_conflict), 64'd0);
        drive_idle();

        @(negedge clk); pre_we = 1; pre_idx = 10'h020; pre_data = 64'hDEADBEEF;
        @(negedge clk); pre_idx = 10'h060; pre_data = 64'hAA;
        @(negedge clk); pre_idx = 10'h3FF; pre_data = 64'h1234;
        @(negedge clk); pre_we = 0;
        reset = 1'b0;

        for (int i = 0; i < 22; i++) apply(i, tbl[i]);

        // Reset arriving while a slot-1 load is held.
        @(negedge clk);
        req0_valid = 1; req0_addr = 64'h100; req1_valid = 1; req1_addr = 64'h200;
        #1;
        chk("pre-reset conflict stall", {63'd0, stall}, 64'd1);
        @(negedge clk);
        drive_idle();
        reset = 1'b1;
        #1;
        $display("mid-held reset: stall=%0b addr=0x%0h cnt=%0d/%0d/%0d",
                 stall, mem_addr, cnt_grant0, cnt_grant1, cnt_conflict);
        chk("midreset stall", {63'd0, stall}, 64'd0);
        chk("midreset mem_addr", mem_addr, 64'd0);
        chk("midreset cnt_grant0", 64'(cnt_grant0), 64'd0);
        chk("midreset cnt_conflict", 64'(cnt_conflict), 64'd0);
        chk("midreset resp0_valid", {63'd0, resp0_valid}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            $display("post-reset cycle %0d: stall=%0b r1=%0b addr=0x%0h", k, stall, resp1_valid, mem_addr);
            chk($sformatf("postreset%0d resp1_valid", k), {63'd0, resp1_valid}, 64'd0);
            chk($sformatf("postreset%0d stall", k), {63'd0, stall}, 64'd0);
            chk($sformatf("postreset%0d mem_addr", k), mem_addr, 64'd0);
            chk($sformatf("postreset%0d cnt_grant1", k), 64'(cnt_grant1), 64'd0);
        end

        // Saturation: 17 slot-0 grants on a 4-bit counter.
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            req0_valid = 1; req0_write = 0; req0_addr = 64'h100;
            #1;
            $display("sat grant %0d: cnt_grant0=%0d", i, cnt_grant0);
            chk($sformatf("sat%0d cnt_grant0", i), 64'(cnt_grant0), (i > 15) ? 64'd15 : 64'(i));
        end
        @(negedge clk);
        drive_idle();
        #1;
        $display("sat final: cnt_grant0=%0d", cnt_grant0);
        chk("sat final cnt_grant0", 64'(cnt_grant0), 64'd15);
        chk("sat final cnt_grant1", 64'(cnt_grant1), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_port_scheduler.md
# dmem_port_scheduler

Sequences the two issue slots' load/store requests onto the core's single unified-memory data port. Two requests in one bundle are serialized in program order: slot 0 goes first, slot 1 is held one cycle and the front end is stalled. Read data returns registered to the requesting slot. The block also drops a held slot‑1 access on a branch flush, rejects out-of-range addresses, and keeps saturating conflict and grant counters.

## Interface
- MEM_BYTES, 524288: size of unified memory in bytes; valid addresses are 0..MEM_BYTES-8.
- CNT_W, 32: width of each performance counter.
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high.
- req0_valid / req1_valid  in  1  slot 0 / slot 1 requests a data access this cycle.
- req0_write / req1_write  in  1  1 = store, 0 = load.
- req0_addr / req1_addr  in  64  byte address.
- req0_wdata / req1_wdata  in  64  store data.
- flush  in  1  taken branch resolved; cancels younger (slot‑1) work.
- mem_addr  out  64  data-port address.
- mem_we  out  1  data-port write enable.
- mem_wdata  out  64  data-port write data.
- mem_rdata  in  64  combinational data-port read data.
- stall  out  1  freeze fetch/decode this cycle.
- resp0_valid / resp1_valid  out  1  load result valid for slot 0 / slot 1.
- resp0_rdata / resp1_rdata  out  64  load result.
- addr_err  out  1  one-cycle pulse: a granted access was out of range.
- cnt_grant0 / cnt_grant1 / cnt_conflict  out  CNT_W  saturating event counters.

## Operation
- States: IDLE and HELD. Hold register: write, addr, wdata.
- IDLE, only req0_valid: grant slot 0. Drive mem_* from req0; stay IDLE.
- IDLE, only req1_valid: grant slot 1 directly; stay IDLE.
- IDLE, both valid: grant slot 0. Capture req1 into the hold register, assert stall, go HELD, cnt_conflict++.
  - If flush is also high, do not capture, do not stall, and stay IDLE. cnt_conflict is still incremented.
- HELD: grant the held request and assert stall; new req*_valid are ignored.
  - Next state is IDLE.
  - If flush is high in HELD, the held access is discarded: mem_we=0, no response, no grant count.
- mem_we = granted & write & in-range. The memory captures the write on the same posedge.
- In-range test: addr <= MEM_BYTES-8, evaluated with full 64-bit unsigned compare.
- Out of range:
  - store is suppressed;
  - load responds with rdata 0;
  - addr_err pulses in the following cycle.
- Idle port: mem_addr=0, mem_we=0, mem_wdata=0.
- Counters:
  - cnt_grant0 / cnt_grant1 increment per granted access, including out-of-range ones;
  - all counters saturate at all-ones with no wrap.

## Timing
- Grant is combinational in the request cycle. Load data is registered: resp*_valid/resp*_rdata appear the cycle after the grant and last one cycle.
- Store latency: the write is visible to a load granted in the next cycle.
- A held slot‑1 load responds two cycles after its request, on resp1_*.
- stall is combinational: high in the conflict cycle (unless flush) and throughout HELD.
- Reset values:
  - state IDLE; hold register 0;
  - resp*_valid 0, resp*_rdata 0;
  - addr_err 0; all counters 0.
  - mem_* and stall are 0 while reset is asserted.
- Reset asserted mid-HELD: the held request is lost and no response is issued.
- Back-to-back conflicts: in the cycle after HELD, state is IDLE and new requests are evaluated normally.

## Structure
- Shared package `tinker_pkg`:
  - `sched_state_t` enum {IDLE, HELD};
  - `mem_req_t` struct {write, addr[63:0], wdata[63:0]};
  - localparam for the default MEM_BYTES.
- One sub-module, `sat_counter` (CNT_W, inc, count). It is instantiated three times.
- The rest is a single always_ff for state, hold register, response registers and addr_err, plus a single always_comb for grant/mem_*/stall.

## Test plan
- Single load: mem[0x100]=0xDEAD_BEEF; req0 load 0x100 → next cycle resp0_valid=1, rdata=0xDEADBEEF; stall never high.
- Same-bundle conflict: req0 store 0x200←5, req1 load 0x200 in one cycle.
  - Required: stall=1 for 2 cycles; cnt_conflict=1.
  - resp1_rdata=5 two cycles after the request; cnt_grant0=cnt_grant1=1.
- Flush cancels the held access: conflict with req1 store 0x300←7, then flush in HELD → mem[0x300] unchanged, no resp1, cnt_grant1=0.
- Flush in the conflict cycle: both valid plus flush → slot 0 granted, stall=0, state stays IDLE, cnt_conflict=1.
- Bounds:
  - req0 store to MEM_BYTES-7 → mem_we=0, addr_err pulse;
  - load at MEM_BYTES-8 → valid data, no error.
- Reset mid-HELD plus saturation: reset during HELD → next cycles show no response and counters 0. Force counter to all-ones, then grant → stays all-ones.
